// File: rtl/arb_mux2to1.sv
// arb_mux2to1: two-channel valid/ready arbiter feeding a one-entry registered output slot (y, sel).
// Define ARB_FIXED_PRIO_EN to replace round-robin tie-breaking with fixed A-over-B priority.
module arb_mux2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel
);
  logic w_load, w_ga, w_gb;
  assign w_load = !y_valid || y_ready;
`ifdef ARB_FIXED_PRIO_EN
  assign w_ga = a_valid;
  assign w_gb = b_valid && !a_valid;
`else
  logic r_last;
  // On a tie, serve whichever channel did not win last time.
  assign w_ga = a_valid && (!b_valid || r_last);
  assign w_gb = b_valid && (!a_valid || !r_last);
  always_ff @(posedge clk)
    if (rst) r_last <= 1'b1;
    else if (w_load && (w_ga || w_gb)) r_last <= w_gb;
`endif
  assign a_ready = !rst && w_load && w_ga;
  assign b_ready = !rst && w_load && w_gb;
  always_ff @(posedge clk)
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      sel     <= 1'b0;
    end else if (w_load) begin
      y_valid <= w_ga || w_gb;
      if (w_ga || w_gb) begin
        y   <= w_gb ? b_data : a_data;
        sel <= w_gb;
      end
    end
endmodule

// File: tb/tb_arb_mux2to1.sv
// tb_arb_mux2to1: directed vector table, multi-cycle sequences and randomized checking against a reference model.
module tb_arb_mux2to1;
  logic clk = 1'b0, rst, a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data, y;
  logic a_ready, b_ready, y_valid, sel;
  int checks = 0, errors = 0;
  logic s_ar, s_br;

  arb_mux2to1 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, capture readies before the edge, leave outputs settled after it.
  task automatic cyc(input logic r, input logic av, input logic [7:0] ad,
                     input logic bv, input logic [7:0] bd, input logic yr);
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    #1;
    s_ar = a_ready; s_br = b_ready;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, av; logic [7:0] ad; logic bv; logic [7:0] bd; logic yr;
    logic ear, ebr, eyv; logic [7:0] ey; logic esel;
  } vec_t;

  // Reference model: the output slot and who was served last.
  bit m_v, m_sel, m_last;
  logic [7:0] m_y;

  task automatic model_step(input logic r, input logic av, input logic [7:0] ad,
                            input logic bv, input logic [7:0] bd, input logic yr,
                            output logic ear, output logic ebr);
    int w;
    bit room;
    room = !m_v || yr;
    w = -1;
    if (!r && room) begin
      if (av && bv) begin
`ifdef ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (m_last == 1'b0) ? 1 : 0;
`endif
      end else if (av) w = 0;
      else if (bv) w = 1;
    end
    ear = (w == 0);
    ebr = (w == 1);
    if (r) begin
      m_v = 0; m_y = 8'h00; m_sel = 0; m_last = 1;
    end else if (room) begin
      if (w >= 0) begin
        m_v = 1; m_y = (w == 1) ? bd : ad; m_sel = (w == 1); m_last = (w == 1);
      end else m_v = 0;
    end
  endtask

  initial begin
    vec_t tv[$];
    logic ear, ebr, av, bv;
    logic [7:0] ad, bd;
    rst = 1; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; y_ready = 0;
    @(posedge clk); #1;
`ifndef ARB_FIXED_PRIO_EN
    //        r  av ad     bv bd     yr  ar br yv y      sel
    tv.push_back('{1, 1, 8'h11, 1, 8'h22, 1, 0, 0, 0, 8'h00, 0});
    tv.push_back('{1, 1, 8'h11, 1, 8'h22, 1, 0, 0, 0, 8'h00, 0});
    tv.push_back('{0, 1, 8'hA0, 1, 8'hB0, 1, 1, 0, 1, 8'hA0, 0});
    tv.push_back('{0, 1, 8'hA1, 1, 8'hB0, 1, 0, 1, 1, 8'hB0, 1});
    tv.push_back('{0, 1, 8'hA1, 1, 8'hB1, 1, 1, 0, 1, 8'hA1, 0});
    tv.push_back('{0, 1, 8'hA2, 1, 8'hB1, 1, 0, 1, 1, 8'hB1, 1});
    tv.push_back('{0, 1, 8'hA2, 1, 8'hB2, 0, 0, 0, 1, 8'hB1, 1});
    tv.push_back('{0, 1, 8'hA2, 1, 8'hB2, 0, 0, 0, 1, 8'hB1, 1});
    tv.push_back('{0, 1, 8'hA2, 1, 8'hB2, 1, 1, 0, 1, 8'hA2, 0});
    tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'hA2, 0});
    tv.push_back('{0, 1, 8'h3C, 0, 8'h00, 1, 1, 0, 1, 8'h3C, 0});
    tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h3C, 0});
    tv.push_back('{0, 0, 8'h00, 1, 8'h55, 1, 0, 1, 1, 8'h55, 1});
    tv.push_back('{0, 1, 8'h66, 1, 8'h56, 0, 0, 0, 1, 8'h55, 1});
    tv.push_back('{0, 1, 8'h66, 1, 8'h56, 0, 0, 0, 1, 8'h55, 1});
    tv.push_back('{0, 1, 8'h66, 1, 8'h56, 0, 0, 0, 1, 8'h55, 1});
    tv.push_back('{0, 1, 8'h66, 1, 8'h56, 1, 1, 0, 1, 8'h66, 0});
    tv.push_back('{0, 1, 8'h77, 0, 8'h56, 1, 1, 0, 1, 8'h77, 0});
    tv.push_back('{1, 1, 8'h78, 1, 8'h57, 1, 0, 0, 0, 8'h00, 0});
    tv.push_back('{0, 1, 8'h78, 1, 8'h57, 1, 1, 0, 1, 8'h78, 0});
    tv.push_back('{0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h78, 0});
    foreach (tv[i]) begin
      cyc(tv[i].r, tv[i].av, tv[i].ad, tv[i].bv, tv[i].bd, tv[i].yr);
      chk($sformatf("v%0d a_ready", i), {7'b0, s_ar}, {7'b0, tv[i].ear});
      chk($sformatf("v%0d b_ready", i), {7'b0, s_br}, {7'b0, tv[i].ebr});
      chk($sformatf("v%0d y_valid", i), {7'b0, y_valid}, {7'b0, tv[i].eyv});
      chk($sformatf("v%0d y", i), y, tv[i].ey);
      chk($sformatf("v%0d sel", i), {7'b0, sel}, {7'b0, tv[i].esel});
    end
`else
    cyc(1, 1, 8'h10, 1, 8'h20, 1);
    chk("fp rst y_valid", {7'b0, y_valid}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'hA0 + 8'(i), 1, 8'hB0, 1);
      chk($sformatf("fp tie%0d a_ready", i), {7'b0, s_ar}, 8'h01);
      chk($sformatf("fp tie%0d b_ready", i), {7'b0, s_br}, 8'h00);
      chk($sformatf("fp tie%0d y", i), y, 8'hA0 + 8'(i));
      chk($sformatf("fp tie%0d sel", i), {7'b0, sel}, 8'h00);
    end
    cyc(0, 0, 8'h00, 1, 8'hB0, 1);
    chk("fp b_ready", {7'b0, s_br}, 8'h01);
    chk("fp b y", y, 8'hB0);
    chk("fp b sel", {7'b0, sel}, 8'h01);
`endif
    // Randomized traffic with producers that hold valid/data until accepted.
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    m_v = 0; m_y = 0; m_sel = 0; m_last = 1;
    av = 0; bv = 0; ad = 0; bd = 0;
    for (int i = 0; i < 600; i++) begin
      logic r, yr;
      if (!av && $urandom_range(0, 3) != 0) begin av = 1; ad = 8'($urandom); end
      if (!bv && $urandom_range(0, 3) != 0) begin bv = 1; bd = 8'($urandom); end
      r = ($urandom_range(0, 49) == 0);
      yr = ($urandom_range(0, 3) != 0);
      model_step(r, av, ad, bv, bd, yr, ear, ebr);
      cyc(r, av, ad, bv, bd, yr);
      chk("rnd a_ready", {7'b0, s_ar}, {7'b0, ear});
      chk("rnd b_ready", {7'b0, s_br}, {7'b0, ebr});
      chk("rnd y_valid", {7'b0, y_valid}, {7'b0, m_v});
      chk("rnd sel", {7'b0, sel}, {7'b0, m_sel});
      chk("rnd y", y, m_y);
      if (s_ar) av = 0;
      if (s_br) bv = 0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
